load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the execute stage and data_memory. Takes one load/store request (RV32I funct3)
//  and drives the word-addressed, word-wide data memory: 1-cycle registered read, no byte enables.
//  Does load lane extraction with sign/zero extension. Sub-word stores use read-modify-write.
//  Flags misaligned and out-of-range accesses without touching memory.
// PARAMETERS
//  DEPTH   128  data memory depth in 32-bit words; word index = req_addr[31:2]
// PORTS
//  clk           in   1   clock; all state on posedge
//  rst           in   1   synchronous, active-high reset
//  req_valid     in   1   request present
//  req_ready     out  1   high only in IDLE; request is accepted when req_valid && req_ready
//  req_we        in   1   1=store, 0=load
//  req_funct3    in   3   LB=000 LH=001 LW=010 LBU=100 LHU=101 | SB=000 SH=001 SW=010
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data; low byte or halfword used for SB/SH
//  rsp_valid     out  1   one-cycle completion pulse; no backpressure
//  rsp_rdata     out  32  load result, valid with rsp_valid; 0 for stores and errors
//  rsp_misalign  out  1   with rsp_valid: LH/LHU/SH addr[0]!=0, or LW/SW addr[1:0]!=0
//  rsp_fault     out  1   with rsp_valid: illegal funct3 (load 011/110/111, store >=011) or addr[31:2]>=DEPTH
//  mem_addr      out  32  word index sent to data_memory (ALUResult port)
//  mem_we        out  1   data_memory memwrite
//  mem_wdata     out  32  data_memory write_data
//  mem_rdata     in   32  data_memory read_data; valid the cycle after mem_addr is presented with mem_we=0
// BEHAVIOUR
//  Reset: state=IDLE; rsp_valid, rsp_misalign, rsp_fault=0; rsp_rdata, mem_addr, mem_wdata=0; mem_we=0.
//  FSM states: IDLE, RD_ISSUE, RD_WAIT, MERGE, WRITE, RESP.
//  At acceptance, latch funct3, we, addr[1:0], wdata. Set mem_addr to the word index.
//  mem_addr holds that value until the FSM returns to IDLE.
//  Decode at acceptance (cycle C0):
//   - error (fault has priority over misalign; both bits are set if both apply) -> RESP;
//     rsp_valid in C1; no memory access.
//   - SW -> WRITE (C1, mem_we=1, mem_wdata=wdata) -> RESP; rsp_valid in C2.
//   - load -> RD_ISSUE (C1) -> RD_WAIT (C2: extract the lane from mem_rdata into rsp_rdata) -> RESP;
//     rsp_valid in C3.
//   - SB/SH -> RD_ISSUE (C1) -> MERGE (C2: replace the lane in mem_rdata, register into mem_wdata)
//     -> WRITE (C3) -> RESP; rsp_valid in C4.
//  Lane rules:
//   - LB/LBU select byte addr[1:0]. LH/LHU select halfword addr[1].
//   - LB/LH sign-extend; LBU/LHU zero-extend.
//   - SB replaces byte addr[1:0]; SH replaces halfword addr[1]. All other bytes are kept.
//  RESP lasts exactly 1 cycle, then IDLE. req_ready returns to 1 the cycle after rsp_valid.
//  mem_we = (state==WRITE) && !rst. It is 0 in every other state, so RD_ISSUE is always a clean read.
//  Reset mid-operation: return to IDLE next edge; drop the response.
//   - rst during WRITE suppresses mem_we, so no partial or stale write reaches memory.
//   - rst during RD_ISSUE/MERGE aborts the RMW; memory is unchanged.
//  A request presented while busy is ignored (req_ready=0); the requester holds it.
//  Back-to-back: a new request can be accepted the cycle after RESP.
//  A store followed by a load to the same word returns the stored data; the write completes before RESP.
// STRUCTURE
//  lsu_pkg: funct3 encodings, state enum, DEPTH-derived index width, lane extract/merge functions.
//  Sub-module lsu_lane_align (combinational): inputs funct3, addr[1:0], mem word, store data;
//  outputs extracted load value and merged store word.
//  Top holds the FSM and the registers.
// TESTING
//  1. SW addr 0x14 data 0x88776655 -> mem_we=1 in C1 with mem_addr=5 and mem_wdata=0x88776655; rsp_valid in C2.
//  2. After 1: LB 0x16 -> 0x00000077; LB 0x17 -> 0xFFFFFF88; LBU 0x17 -> 0x00000088;
//     LH 0x16 -> 0xFFFF8877; LW 0x14 -> 0x88776655; each with rsp_valid in C3.
//  3. After 1: SB 0x15 wdata 0x123456AB -> write in C3 of 0x8877AB55; SH 0x16 wdata 0xBEEF
//     -> 0xBEEFAB55; then LW 0x14 reads 0xBEEFAB55.
//  4. LH 0x13 and SW 0x16 -> rsp_misalign=1 in C1, mem_we never 1. LW 0x200 -> rsp_fault=1.
//     Load funct3=011 -> rsp_fault=1.
//  5. SB 0x15 with rst asserted in the MERGE cycle, then again in the WRITE cycle -> mem_we stays 0,
//     no rsp_valid, word 5 unchanged, req_ready=1 the cycle after rst.
//  6. Hold req_valid through a busy load -> exactly one acceptance per RESP; random load/store stream
//     checked against a byte-array model.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit: funct3 codes, FSM states,
// lane extraction/merge and request decode.
package lsu_pkg;

  localparam int unsigned LSU_DEPTH = 128;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_MERGE,
    ST_WRITE,
    ST_RESP
  } lsu_state_e;

  function automatic logic [31:0] lane_extract(input logic [2:0]  funct3,
                                               input logic [1:0]  addr_lo,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'h0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [2:0]  funct3,
                                             input logic [1:0]  addr_lo,
                                             input logic [31:0] word,
                                             input logic [31:0] wdata);
    logic [31:0] r;
    r = word;
    case (funct3)
      F3_B: r[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (addr_lo[1]) r[31:16] = wdata[15:0];
        else            r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  function automatic logic is_fault(input logic        we,
                                    input logic [2:0]  funct3,
                                    input logic [29:0] word_idx,
                                    input int unsigned depth);
    logic legal;
    if (we) legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else    legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                    (funct3 == F3_BU) || (funct3 == F3_HU);
    return !legal || ({2'b00, word_idx} >= depth);
  endfunction

  function automatic logic is_misaligned(input logic       we,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic half;
    half = (funct3 == F3_H) || (!we && (funct3 == F3_HU));
    return (half && addr_lo[0]) || ((funct3 == F3_W) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane logic: extracts the load value from a memory word and builds
// the merged word for sub-word stores.
import lsu_pkg::*;

module lsu_lane_align (
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] mem_word_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_value_o,
  output logic [31:0] merged_word_o
);

  assign load_value_o  = lane_extract(funct3_i, addr_lo_i, mem_word_i);
  assign merged_word_o = lane_merge(funct3_i, addr_lo_i, mem_word_i, store_data_i);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-wide, 1-cycle-read data memory. Sub-word stores
// are done as read-modify-write; misaligned/illegal/out-of-range requests never touch memory.
import lsu_pkg::*;

module load_store_unit #(
  parameter int unsigned DEPTH = LSU_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_misalign,
  output logic        rsp_fault,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        misalign_q, misalign_d;
  logic        fault_q, fault_d;

  logic        req_fault, req_misalign;
  logic [31:0] load_value, merged_word;

  assign req_fault    = is_fault(req_we, req_funct3, req_addr[31:2], DEPTH);
  assign req_misalign = is_misaligned(req_we, req_funct3, req_addr[1:0]);

  lsu_lane_align u_lane_align (
    .funct3_i      (funct3_q),
    .addr_lo_i     (addr_lo_q),
    .mem_word_i    (mem_rdata),
    .store_data_i  (mem_wdata_q),
    .load_value_o  (load_value),
    .merged_word_o (merged_word)
  );

  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    we_d        = we_q;
    addr_lo_d   = addr_lo_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    misalign_d  = misalign_q;
    fault_d     = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          funct3_d    = req_funct3;
          we_d        = req_we;
          addr_lo_d   = req_addr[1:0];
          mem_addr_d  = {2'b00, req_addr[31:2]};
          mem_wdata_d = req_wdata;
          rsp_rdata_d = '0;
          misalign_d  = req_misalign;
          fault_d     = req_fault;
          if (req_fault || req_misalign)          state_d = ST_RESP;
          else if (req_we && req_funct3 == F3_W)  state_d = ST_WRITE;
          else                                    state_d = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: state_d = we_q ? ST_MERGE : ST_RD_WAIT;
      ST_RD_WAIT: begin
        rsp_rdata_d = load_value;
        state_d     = ST_RESP;
      end
      // mem_wdata_q still holds the store data here; the merged word replaces it.
      ST_MERGE: begin
        mem_wdata_d = merged_word;
        state_d     = ST_WRITE;
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      funct3_q    <= '0;
      we_q        <= 1'b0;
      addr_lo_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
      misalign_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      we_q        <= we_d;
      addr_lo_q   <= addr_lo_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      misalign_q  <= misalign_d;
      fault_q     <= fault_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_misalign = rsp_valid && misalign_q;
  assign rsp_fault    = rsp_valid && fault_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  // Reset in the WRITE cycle must block the write the same cycle.
  assign mem_we       = (state_q == ST_WRITE) && !rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural data memory and a
// byte-array reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_misalign, rsp_fault;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_total = 0;
  int rsp_total = 0;
  logic [31:0] wr_addr_last, wr_data_last;
  int          wr_cyc_last;

  logic [31:0] dmem [0:127] = '{default: 32'h0};
  logic [7:0]  rb [0:511];

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH(128)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_misalign(rsp_misalign), .rsp_fault(rsp_fault),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // data_memory: word-addressed, write on mem_we, registered read
  always @(posedge clk) begin
    if (mem_we && mem_addr < 32'd128) dmem[mem_addr[6:0]] <= mem_wdata;
    mem_rdata <= (mem_addr < 32'd128) ? dmem[mem_addr[6:0]] : 32'h0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_total     <= wr_total + 1;
      wr_addr_last <= mem_addr;
      wr_data_last <= mem_wdata;
      wr_cyc_last  <= cyc;
    end
    if (rsp_valid) rsp_total <= rsp_total + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]};
  endfunction

  task automatic do_req(input string nm, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_mis, input logic exp_flt,
                        input int exp_lat, input logic exp_wr, input logic [31:0] exp_wd);
    int lat;
    int acc;
    int wr0;
    @(negedge clk);
    check({nm, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    acc = cyc;
    wr0 = wr_total;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      checks++;
      failures++;
      $display("FAIL %s.timeout: got no rsp_valid expected rsp_valid in C%0d", nm, exp_lat);
    end else begin
      check({nm, ".latency"}, 32'(lat), 32'(exp_lat));
      check({nm, ".rdata"}, rsp_rdata, exp_rdata);
      check({nm, ".misalign"}, 32'(rsp_misalign), 32'(exp_mis));
      check({nm, ".fault"}, 32'(rsp_fault), 32'(exp_flt));
    end
    @(negedge clk);
    check({nm, ".pulse"}, 32'(rsp_valid), 32'd0);
    check({nm, ".ready_after"}, 32'(req_ready), 32'd1);
    check({nm, ".writes"}, 32'(wr_total - wr0), 32'(exp_wr));
    if (exp_wr) begin
      check({nm, ".wr_addr"}, wr_addr_last, {2'b00, addr[31:2]});
      check({nm, ".wr_data"}, wr_data_last, exp_wd);
      check({nm, ".wr_cycle"}, 32'(wr_cyc_last - acc), 32'(exp_lat - 1));
      for (int k = 0; k < 4; k++) rb[4*addr[31:2] + k] = exp_wd[8*k +: 8];
    end
    $display("txn %s we=%0d f3=%0d addr=%h wdata=%h -> rdata=%h mis=%0d flt=%0d lat=%0d",
             nm, we, f3, addr, wdata, rsp_rdata, exp_mis, exp_flt, lat);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mis;
    logic        flt;
    int          lat;
    logic        wr;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs [22];

  initial begin
    int wr0, r0, acc_n, rsp_n;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a, wd, exp;
    int          w, off, sel;

    vecs[0]  = '{1'b1, 3'd2, 32'h014, 32'h88776655, 32'h0,        1'b0, 1'b0, 2, 1'b1, 32'h88776655};
    vecs[1]  = '{1'b0, 3'd0, 32'h016, 32'h0,        32'h00000077, 1'b0, 1'b0, 3, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 3'd0, 32'h017, 32'h0,        32'hFFFFFF88, 1'b0, 1'b0, 3, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 3'd4, 32'h017, 32'h0,        32'h00000088, 1'b0, 1'b0, 3, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 3'd1, 32'h016, 32'h0,        32'hFFFF8877, 1'b0, 1'b0, 3, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 3'd2, 32'h014, 32'h0,        32'h88776655, 1'b0, 1'b0, 3, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 3'd0, 32'h015, 32'h123456AB, 32'h0,        1'b0, 1'b0, 4, 1'b1, 32'h8877AB55};
    vecs[7]  = '{1'b1, 3'd1, 32'h016, 32'h0000BEEF, 32'h0,        1'b0, 1'b0, 4, 1'b1, 32'hBEEFAB55};
    vecs[8]  = '{1'b0, 3'd2, 32'h014, 32'h0,        32'hBEEFAB55, 1'b0, 1'b0, 3, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 3'd1, 32'h013, 32'h0,        32'h0,        1'b1, 1'b0, 1, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 3'd2, 32'h016, 32'hDEADBEEF, 32'h0,        1'b1, 1'b0, 1, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 3'd2, 32'h200, 32'h0,        32'h0,        1'b0, 1'b1, 1, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 3'd3, 32'h014, 32'h0,        32'h0,        1'b0, 1'b1, 1, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 3'd5, 32'h016, 32'h0,        32'h0000BEEF, 1'b0, 1'b0, 3, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 3'd0, 32'h015, 32'h0,        32'hFFFFFFAB, 1'b0, 1'b0, 3, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 3'd1, 32'h014, 32'h0,        32'hFFFFAB55, 1'b0, 1'b0, 3, 1'b0, 32'h0};
    vecs[16] = '{1'b1, 3'd3, 32'h014, 32'h11111111, 32'h0,        1'b0, 1'b1, 1, 1'b0, 32'h0};
    vecs[17] = '{1'b0, 3'd2, 32'h203, 32'h0,        32'h0,        1'b1, 1'b1, 1, 1'b0, 32'h0};
    vecs[18] = '{1'b1, 3'd2, 32'h1FC, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0, 2, 1'b1, 32'hCAFEF00D};
    vecs[19] = '{1'b0, 3'd2, 32'h1FC, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0, 3, 1'b0, 32'h0};
    vecs[20] = '{1'b0, 3'd4, 32'h1FF, 32'h0,        32'h000000CA, 1'b0, 1'b0, 3, 1'b0, 32'h0};
    vecs[21] = '{1'b0, 3'd0, 32'h1FC, 32'h0,        32'h0000000D, 1'b0, 1'b0, 3, 1'b0, 32'h0};

    for (int i = 0; i < 512; i++) rb[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset.rsp_misalign", 32'(rsp_misalign), 32'd0);
    check("reset.rsp_fault", 32'(rsp_fault), 32'd0);
    check("reset.rsp_rdata", rsp_rdata, 32'h0);
    check("reset.mem_addr", mem_addr, 32'h0);
    check("reset.mem_wdata", mem_wdata, 32'h0);
    check("reset.mem_we", 32'(mem_we), 32'd0);
    check("reset.req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 22; i++)
      do_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
             vecs[i].rdata, vecs[i].mis, vecs[i].flt, vecs[i].lat, vecs[i].wr, vecs[i].wd);

    // Reset in MERGE, then in WRITE, of an SB to word 5
    wr0 = wr_total; r0 = rsp_total;
    for (int phase = 2; phase <= 3; phase++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h15; req_wdata = 32'h000000CC;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (phase - 1) @(negedge clk);
      rst = 1'b1;
      #1;
      check($sformatf("rst_c%0d.mem_we", phase), 32'(mem_we), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check($sformatf("rst_c%0d.req_ready", phase), 32'(req_ready), 32'd1);
      check($sformatf("rst_c%0d.rsp_valid", phase), 32'(rsp_valid), 32'd0);
      $display("txn rst_c%0d SB addr=00000015 reset in C%0d", phase, phase);
    end
    repeat (4) @(negedge clk);
    check("rst.writes", 32'(wr_total - wr0), 32'd0);
    check("rst.responses", 32'(rsp_total - r0), 32'd0);
    do_req("rst.readback", 1'b0, 3'd2, 32'h14, 32'h0, 32'hBEEFAB55, 1'b0, 1'b0, 3, 1'b0, 32'h0);

    // Requester holds req_valid across busy loads
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h14;
    acc_n = 0; rsp_n = 0;
    for (int i = 0; i < 12; i++) begin
      if (req_ready) acc_n++;
      if (rsp_valid) begin
        rsp_n++;
        check("hold.rdata", rsp_rdata, 32'hBEEFAB55);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("hold.accepts", 32'(acc_n), 32'd3);
    check("hold.responses", 32'(rsp_n), 32'd3);
    $display("txn hold LW addr=00000014 accepts=%0d responses=%0d", acc_n, rsp_n);

    // Random legal, aligned stream over words 0..7 against the byte model
    for (int i = 0; i < 40; i++) begin
      we  = 1'($urandom_range(0, 1));
      w   = int'($urandom_range(0, 7));
      off = int'($urandom_range(0, 3));
      wd  = $urandom;
      if (we) begin
        sel = int'($urandom_range(0, 2));
        f3  = 3'(sel);
      end else begin
        sel = int'($urandom_range(0, 4));
        f3  = (sel < 3) ? 3'(sel) : 3'(sel + 1);
      end
      if (f3[1:0] == 2'b01) off = off & 2;
      if (f3[1:0] == 2'b10) off = 0;
      a = 32'(w * 4 + off);
      if (we) begin
        rb[a] = wd[7:0];
        if (f3[1:0] != 2'b00) rb[a+1] = wd[15:8];
        if (f3[1:0] == 2'b10) begin
          rb[a+2] = wd[23:16];
          rb[a+3] = wd[31:24];
        end
        do_req($sformatf("rnd%0d", i), 1'b1, f3, a, wd, 32'h0, 1'b0, 1'b0,
               (f3 == 3'd2) ? 2 : 4, 1'b1, ref_word(w));
      end else begin
        case (f3)
          3'd0:    exp = {{24{rb[a][7]}}, rb[a]};
          3'd4:    exp = {24'h0, rb[a]};
          3'd1:    exp = {{16{rb[a+1][7]}}, rb[a+1], rb[a]};
          3'd5:    exp = {16'h0, rb[a+1], rb[a]};
          default: exp = ref_word(w);
        endcase
        do_req($sformatf("rnd%0d", i), 1'b0, f3, a, 32'h0, exp, 1'b0, 1'b0, 3, 1'b0, 32'h0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
